i2s_receive_fifo: RTL

//  Parametrised I2S / left-justified serial audio receiver, sck domain. Deserialises

---
 rtl/i2s_receive_fifo_if.sv | 43 ++++
 rtl/i2s_receive_fifo.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/i2s_receive_fifo_if.sv
// i2s_receive_fifo_if: serial audio input, frame FIFO output and status pulses
// of the I2S receive FIFO. The source/consumer side uses modport master, the
// receiver uses modport slave.
interface i2s_receive_fifo_if #(
   parameter int unsigned DATA_WIDTH = 24,
   parameter int unsigned FIFO_DEPTH = 4
);
   localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;

   logic                  ws;
   logic                  sd;
   logic [DATA_WIDTH-1:0] data_left;
   logic [DATA_WIDTH-1:0] data_right;
   logic                  frame_valid;
   logic                  frame_ready;
   logic [LevelW-1:0]     fifo_level;
   logic                  overrun;
   logic                  slot_err;

   modport master (
      output ws,
      output sd,
      output frame_ready,
      input  data_left,
      input  data_right,
      input  frame_valid,
      input  fifo_level,
      input  overrun,
      input  slot_err
   );

   modport slave (
      input  ws,
      input  sd,
      input  frame_ready,
      output data_left,
      output data_right,
      output frame_valid,
      output fifo_level,
      output overrun,
      output slot_err
   );
endinterface

// File: rtl/i2s_receive_fifo.sv
// i2s_receive_fifo: I2S / left-justified stereo receiver in the sck domain.
// Deserialises each slot MSB first into DATA_WIDTH bits, pairs left+right into
// frames and buffers them in a FIFO_DEPTH first-word-fall-through frame FIFO.
// Optional slot-length checking is compiled in with I2S_RX_SLOT_CHECK_EN.
module i2s_receive_fifo #(
   parameter int unsigned DATA_WIDTH = 24,
   parameter int unsigned SLOT_BITS  = 32,
   parameter int unsigned JUSTIFY    = 0,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input logic               sck,
   input logic               rst,
   i2s_receive_fifo_if.slave bus
);
   localparam int unsigned AddrW  = $clog2(FIFO_DEPTH);
   localparam int unsigned LevelW = AddrW + 1;
   localparam logic [5:0]  CntMax = 6'd63;

`ifdef I2S_RX_SLOT_CHECK_EN
   localparam bit SlotCheckEn = 1'b1;
`else
   localparam bit SlotCheckEn = 1'b0;
`endif

   typedef enum logic [1:0] {
      StHunt,
      StLeft,
      StRight
   } state_e;

   // Slot alignment and deserialiser state
   logic                  wsd_q;
   logic                  wsa;
   logic                  wsa_d_q;
   logic                  slot_start;
   logic [5:0]            cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] hold_l_q, hold_r_q;
   logic                  len_bad;

   // Frame assembly FSM state
   state_e                state_q;
   logic                  push_q;
   logic                  bad_q;
   logic                  slot_err_q;

   // Frame FIFO state
   logic [DATA_WIDTH-1:0] mem_l_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_r_q [FIFO_DEPTH];
   logic [AddrW-1:0]      wr_ptr_q;
   logic [AddrW-1:0]      rd_ptr_q;
   logic [LevelW-1:0]     level_q;
   logic                  overrun_q;
   logic                  fifo_full;
   logic                  fifo_valid;
   logic                  pop;
   logic                  do_push;

   // I2S mode looks at ws delayed by one sck so the MSB lands on the slot start edge
   assign wsa        = (JUSTIFY != 0) ? bus.ws : wsd_q;
   assign slot_start = (wsa != wsa_d_q);

   // At a slot start cnt_q holds the finished slot's length in sck cycles
   assign len_bad = SlotCheckEn && (32'(cnt_q) != SLOT_BITS);

   // Next bit count and shift contents: restart at a slot edge, else place bit k
   always_comb begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
      if (slot_start) begin
         cnt_d                   = 6'd1;
         shift_d                 = '0;
         shift_d[DATA_WIDTH-1]   = bus.sd;
      end else begin
         if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 6'd1;
         end
         // bits at k >= DATA_WIDTH match no position and are dropped
         for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (32'(cnt_q) == DATA_WIDTH - 1 - i) begin
               shift_d[i] = bus.sd;
            end
         end
      end
   end

   // Deserialiser registers; the finished slot moves to its hold at each slot start
   always_ff @(posedge sck) begin
      if (rst) begin
         wsd_q    <= 1'b0;
         wsa_d_q  <= 1'b0;
         cnt_q    <= '0;
         shift_q  <= '0;
         hold_l_q <= '0;
         hold_r_q <= '0;
      end else begin
         wsd_q   <= bus.ws;
         wsa_d_q <= wsa;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         if (slot_start) begin
            if (wsa_d_q) begin
               hold_r_q <= shift_q;
            end else begin
               hold_l_q <= shift_q;
            end
         end
      end
   end

   // Frame FSM: wait for a left slot start, then pair left/right and request a push
   always_ff @(posedge sck) begin
      if (rst) begin
         state_q    <= StHunt;
         push_q     <= 1'b0;
         bad_q      <= 1'b0;
         slot_err_q <= 1'b0;
      end else begin
         push_q     <= 1'b0;
         slot_err_q <= 1'b0;
         if (slot_start) begin
            case (state_q)
               StHunt: begin
                  if (!wsa) begin
                     state_q <= StLeft;
                     bad_q   <= 1'b0;
                  end
               end
               StLeft: begin
                  // left slot just finished; ws alternation guarantees wsa = 1 here
                  slot_err_q <= len_bad;
                  bad_q      <= len_bad;
                  state_q    <= StRight;
               end
               StRight: begin
                  // right slot just finished; frame is complete unless a slot was bad
                  slot_err_q <= len_bad;
                  push_q     <= !(bad_q || len_bad);
                  bad_q      <= 1'b0;
                  state_q    <= StLeft;
               end
               default: begin
                  state_q <= StHunt;
               end
            endcase
         end
      end
   end

   assign fifo_valid = (level_q != '0);
   assign fifo_full  = (level_q == LevelW'(FIFO_DEPTH));
   assign pop        = fifo_valid && bus.frame_ready;
   // a pop on the same edge frees the slot the push needs
   assign do_push    = push_q && (!fifo_full || pop);

   // FIFO pointers, level and overrun pulse
   always_ff @(posedge sck) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= push_q && fifo_full && !pop;
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + AddrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AddrW'(1);
         end
         case ({do_push, pop})
            2'b10:   level_q <= level_q + LevelW'(1);
            2'b01:   level_q <= level_q - LevelW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // FIFO storage; contents need no reset since the level gates visibility
   always_ff @(posedge sck) begin
      if (!rst && do_push) begin
         mem_l_q[wr_ptr_q] <= hold_l_q;
         mem_r_q[wr_ptr_q] <= hold_r_q;
      end
   end

   assign bus.frame_valid = fifo_valid;
   assign bus.data_left   = fifo_valid ? mem_l_q[rd_ptr_q] : '0;
   assign bus.data_right  = fifo_valid ? mem_r_q[rd_ptr_q] : '0;
   assign bus.fifo_level  = level_q;
   assign bus.overrun     = overrun_q;
   assign bus.slot_err    = slot_err_q;
endmodule
